branch_prediction_unit: RTL

//  Parametrised branch predictor plus resolver. IF stage: direct-mapped BTB/BHT lookup
//  (tag, target, 2-bit saturating counter, jump flag) gives next-PC prediction.
//  EX stage: resolves JUMP/BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU), detects mispredict,

---
 rtl/branch_prediction_unit_pkg.sv | 38 +++
 rtl/branch_prediction_unit_if.sv | 42 ++++
 rtl/branch_prediction_unit_resolve.sv | 56 +++++
 rtl/branch_prediction_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/branch_prediction_unit_pkg.sv
// Shared definitions for the branch prediction unit: branch condition codes,
// 2-bit saturating counter encodings, entry field widths and the counter step.
package branch_pkg;

    // Conditional-branch func3 codes; 3'b010 and 3'b011 are not branch conditions.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Two-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    // Fixed-width fields of a table entry (tag width is a module parameter).
    localparam int CNT_W   = 2;
    localparam int VALID_W = 1;
    localparam int JUMP_W  = 1;

    // One training step of the direction counter, saturating at both ends.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (taken && cnt != CNT_ST)
            nxt = cnt + 2'b01;
        else if (!taken && cnt != CNT_SNT)
            nxt = cnt - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_prediction_unit_if.sv
// Pipeline-facing bus of the branch prediction unit: fetch-stage lookup,
// execute-stage resolution inputs, redirect outputs and performance counters.
interface branch_prediction_unit_if #(
    parameter int XLEN = 32
);
    // Fetch-stage lookup
    logic [XLEN-1:0] IF_PC;
    logic            PRED_TAKEN;
    logic [XLEN-1:0] PRED_TARGET;

    // Execute-stage resolution
    logic            EX_VALID;
    logic [XLEN-1:0] EX_PC;
    logic            EX_JUMP;
    logic            EX_BRANCH;
    logic [2:0]      EX_FUNC3;
    logic [XLEN-1:0] EX_OUT1;
    logic [XLEN-1:0] EX_OUT2;
    logic [XLEN-1:0] EX_ALU_RESULT;
    logic            EX_PRED_TAKEN;
    logic [XLEN-1:0] EX_PRED_TARGET;

    // Redirect and statistics
    logic            FLUSH;
    logic [XLEN-1:0] REDIRECT_PC;
    logic [31:0]     BR_COUNT;
    logic [31:0]     MISPRED_COUNT;

    // Pipeline side: supplies PCs and EX state, consumes predictions/redirects.
    modport master (
        output IF_PC, EX_VALID, EX_PC, EX_JUMP, EX_BRANCH, EX_FUNC3,
               EX_OUT1, EX_OUT2, EX_ALU_RESULT, EX_PRED_TAKEN, EX_PRED_TARGET,
        input  PRED_TAKEN, PRED_TARGET, FLUSH, REDIRECT_PC, BR_COUNT, MISPRED_COUNT
    );

    // Predictor side.
    modport slave (
        input  IF_PC, EX_VALID, EX_PC, EX_JUMP, EX_BRANCH, EX_FUNC3,
               EX_OUT1, EX_OUT2, EX_ALU_RESULT, EX_PRED_TAKEN, EX_PRED_TARGET,
        output PRED_TAKEN, PRED_TARGET, FLUSH, REDIRECT_PC, BR_COUNT, MISPRED_COUNT
    );
endinterface

// File: rtl/branch_prediction_unit_resolve.sv
// Combinational EX-stage resolver: actual direction and target of a control
// instruction, misprediction against the carried prediction, and the correct next PC.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_ex_valid,
    input  logic            i_ex_jump,
    input  logic            i_ex_branch,
    input  logic [2:0]      i_ex_func3,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_out1,
    input  logic [XLEN-1:0] i_ex_out2,
    input  logic [XLEN-1:0] i_ex_alu_result,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_ctl,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target,
    output logic            o_mispredict,
    output logic            o_update_en,
    output logic [XLEN-1:0] o_redirect_pc
);

    logic w_cond;
    logic w_func3_ok;

    // Evaluate the branch condition selected by func3.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it
        // unassigned and no latch is inferred; blocking '=' is correct in combinational code.
        w_cond     = 1'b0;
        w_func3_ok = 1'b1;
        case (i_ex_func3)
            F3_BEQ:  w_cond = (i_ex_out1 == i_ex_out2);
            F3_BNE:  w_cond = (i_ex_out1 != i_ex_out2);
            F3_BLT:  w_cond = ($signed(i_ex_out1) <  $signed(i_ex_out2));
            F3_BGE:  w_cond = ($signed(i_ex_out1) >= $signed(i_ex_out2));
            F3_BLTU: w_cond = (i_ex_out1 <  i_ex_out2);
            F3_BGEU: w_cond = (i_ex_out1 >= i_ex_out2);
            default: w_func3_ok = 1'b0;
        endcase
    end

    // A jump always wins over the branch flag; jump targets are halfword aligned.
    assign o_ctl       = i_ex_valid & (i_ex_jump | i_ex_branch);
    assign o_taken     = i_ex_jump | (i_ex_branch & w_cond);
    assign o_target    = i_ex_jump ? {i_ex_alu_result[XLEN-1:1], 1'b0} : i_ex_alu_result;
    assign o_update_en = o_ctl & (i_ex_jump | w_func3_ok);

    assign o_mispredict  = o_ctl & ((o_taken != i_ex_pred_taken) |
                                    (o_taken & (o_target != i_ex_pred_target)));
    assign o_redirect_pc = o_taken ? o_target : i_ex_pc + XLEN'(4);

endmodule

// File: rtl/branch_prediction_unit.sv
// Direct-mapped BTB/BHT with zero-latency fetch lookup, EX-stage training,
// mispredict flush/redirect and saturating performance counters.
module branch_prediction_unit
    import branch_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 64,    // power of two, at least 2
    parameter int         TAG_W    = 8,     // IDX_W + TAG_W + 2 must not exceed XLEN
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic                    CLK,
    input  logic                    RESET,
    branch_prediction_unit_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Table storage
    logic                 r_valid   [ENTRIES];
    logic [TAG_W-1:0]     r_tag     [ENTRIES];
    logic [XLEN-1:0]      r_target  [ENTRIES];
    logic [CNT_W-1:0]     r_cnt     [ENTRIES];
    logic                 r_is_jump [ENTRIES];
    logic [31:0]          r_br_count;
    logic [31:0]          r_mispred_count;

    // Lookup and resolve wires
    logic [IDX_W-1:0]     w_if_idx;
    logic [TAG_W-1:0]     w_if_tag;
    logic                 w_if_hit;
    logic [IDX_W-1:0]     w_ex_idx;
    logic [TAG_W-1:0]     w_ex_tag;
    logic                 w_ex_hit;
    logic                 w_ctl;
    logic                 w_taken;
    logic [XLEN-1:0]      w_target;
    logic                 w_mispredict;
    logic                 w_update_en;
    logic [XLEN-1:0]      w_redirect_pc;
    logic                 w_unused_if_pc;

    // Index and tag come from fixed PC slices above the word offset.
    assign w_if_idx = bus.IF_PC[IDX_W+1:2];
    assign w_if_tag = bus.IF_PC[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ex_idx = bus.EX_PC[IDX_W+1:2];
    assign w_ex_tag = bus.EX_PC[IDX_W+TAG_W+1:IDX_W+2];

    // High PC bits beyond the tag do not take part in the lookup.
    assign w_unused_if_pc = ^bus.IF_PC;

    // Fetch lookup reads the current table contents, so a same-cycle update is not visible.
    assign w_if_hit        = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign bus.PRED_TAKEN  = !RESET && w_if_hit && (r_is_jump[w_if_idx] || r_cnt[w_if_idx][1]);
    assign bus.PRED_TARGET = (!RESET && w_if_hit) ? r_target[w_if_idx] : '0;

    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    branch_resolve #(
        .XLEN (XLEN)
    ) u_resolve (
        .i_ex_valid       (bus.EX_VALID),
        .i_ex_jump        (bus.EX_JUMP),
        .i_ex_branch      (bus.EX_BRANCH),
        .i_ex_func3       (bus.EX_FUNC3),
        .i_ex_pc          (bus.EX_PC),
        .i_ex_out1        (bus.EX_OUT1),
        .i_ex_out2        (bus.EX_OUT2),
        .i_ex_alu_result  (bus.EX_ALU_RESULT),
        .i_ex_pred_taken  (bus.EX_PRED_TAKEN),
        .i_ex_pred_target (bus.EX_PRED_TARGET),
        .o_ctl            (w_ctl),
        .o_taken          (w_taken),
        .o_target         (w_target),
        .o_mispredict     (w_mispredict),
        .o_update_en      (w_update_en),
        .o_redirect_pc    (w_redirect_pc)
    );

    // Redirect outputs are silent during reset and whenever there is no mispredict.
    assign bus.FLUSH         = !RESET && w_mispredict;
    assign bus.REDIRECT_PC   = bus.FLUSH ? w_redirect_pc : '0;
    assign bus.BR_COUNT      = r_br_count;
    assign bus.MISPRED_COUNT = r_mispred_count;

    // Train a hitting entry or allocate over the victim on a taken miss.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the table is built from flops rather than a RAM macro, which is what
            // lets reset clear every entry in a single cycle; use '<=' for all state.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]   <= 1'b0;
                r_tag[i]     <= '0;
                r_target[i]  <= '0;
                r_cnt[i]     <= CNT_INIT;
                r_is_jump[i] <= 1'b0;
            end
        end else if (w_update_en) begin
            if (w_ex_hit) begin
                r_cnt[w_ex_idx] <= cnt_step(r_cnt[w_ex_idx], w_taken);
                if (w_taken)
                    r_target[w_ex_idx] <= w_target;
            end else if (w_taken) begin
                r_valid[w_ex_idx]   <= 1'b1;
                r_tag[w_ex_idx]     <= w_ex_tag;
                r_target[w_ex_idx]  <= w_target;
                r_cnt[w_ex_idx]     <= CNT_WT;
                r_is_jump[w_ex_idx] <= bus.EX_JUMP;
            end
        end
    end

    // Count resolved control instructions and mispredictions, holding at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_ctl && r_br_count != '1)
                r_br_count <= r_br_count + 32'd1;
            if (w_mispredict && r_mispred_count != '1)
                r_mispred_count <= r_mispred_count + 32'd1;
        end
    end

endmodule
